psum_drain: RTL and testbench
=============================

// Module: psum_drain
// PURPOSE
//  Reader end of the systolic-array accumulator chain. The truncating adders write partial sums
//  into each PE accumulator; this block reads them back out. On start it shifts N_ROWS sums out
//  of one array column, one per cycle, and buffers them in a small FIFO. It streams them to the
//  output SRAM feeder over valid/ready.
// PARAMETERS
//  OC_W        16  width of accumulator / partial sum (matches adder output width)
//  A_APPROX    0   LSBs zeroed by the truncating adders (0 = exact)
//  N_ROWS      8   sums drained per start (>=1)
//  FIFO_DEPTH  4   output buffer entries (power of 2, >=2)
// PORTS
//  i_clk     in   1                 clock, rising edge
//  i_rstn    in   1                 asynchronous active-low reset
//  i_start   in   1                 pulse: begin drain of N_ROWS sums (ignored unless IDLE)
//  i_abort   in   1                 sync abort: flush FIFO, return to IDLE, no o_done
//  i_c_in    in   OC_W              head-of-chain accumulator value, valid while o_shift=1
//  o_shift   out  1                 shift the column chain by one this cycle
//  o_data    out  OC_W              FIFO head (post-compensation)
//  o_valid   out  1                 o_data valid
//  i_ready   in   1                 consumer accepts o_data when o_valid & i_ready
//  o_busy    out  1                 state != IDLE
//  o_done    out  1                 1-cycle pulse: all N_ROWS sums consumed
// BEHAVIOUR
//  Reset (async, i_rstn=0): state=IDLE, FIFO empty, row count=0.
//   Outputs during reset: o_shift=0, o_valid=0, o_busy=0, o_done=0, o_data=0.
//  FSM: IDLE -> SHIFT on i_start. SHIFT -> FLUSH after the N_ROWS-th push.
//   FLUSH -> DONE when FIFO empty. DONE -> IDLE unconditionally (o_done=1 in DONE only).
//  SHIFT: o_shift = !full. When high, i_c_in is pushed the same cycle and row_cnt increments.
//   Full is based on the registered count, so a pop in the same cycle does not enable a push.
//  Pop: o_valid = !empty, o_data = mem[rd_ptr] (combinational read), pop on o_valid & i_ready.
//   Pops are allowed in every state except IDLE after abort.
//   Simultaneous push and pop when not full leaves the count unchanged.
//  Latency: push at cycle t; o_valid at t+1 earliest.
//   Fully streamed N_ROWS=8 with i_ready=1: o_done asserts at cycle t0+N_ROWS+2 after start.
//  Pointers wrap modulo FIFO_DEPTH. Count has log2(FIFO_DEPTH)+1 bits.
//  i_abort has priority over everything except reset:
//   next cycle state=IDLE, FIFO empty, row_cnt=0, no o_done, o_shift=0 in the abort cycle.
//  i_start while busy: ignored. i_start coincident with i_abort: abort wins.
//  i_ready=0 indefinitely: SHIFT stalls with o_shift=0 once full. Data is never dropped.
//  Widths: sums are two's complement OC_W. No saturation. Compensation never changes bits above A_APPROX-1.
// CONFIGURATION
//  Macro PSUM_DRAIN_BIAS_COMP_EN:
//   Defined and A_APPROX>0: each pushed value has bits [A_APPROX-1:0] replaced by 1 followed by
//    (A_APPROX-1) zeros (midpoint), which offsets the negative truncation bias.
//   Undefined, or A_APPROX==0: i_c_in is pushed unmodified.
// STRUCTURE
//  psum_drain_pkg: typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} drain_state_t.
//   It also holds the function comp_lsb(val, approx) used for compensation.
//  Sub-module psum_fifo #(W, DEPTH): synchronous FIFO with async active-low reset,
//   push/pop/full/empty/head. It has no knowledge of rows or the FSM.
// TESTING
//  1. N_ROWS=8, i_c_in=1..8, i_ready=1, start -> o_shift high 8 cycles; o_data 1..8 in order;
//     single o_done; o_busy falls with it.
//  2. i_ready=0 after start, FIFO_DEPTH=4 -> exactly 4 shifts, then o_shift=0;
//     raise i_ready -> remaining 4 shifted, 8 outputs in order, no loss.
//  3. Random i_ready (50%), i_c_in = -3,-2,...,4 -> output order and values exact;
//     o_valid never drops before pop.
//  4. i_abort after 3 pushes -> next cycle o_busy=0, o_valid=0, no o_done;
//     new start drains 8 fresh values correctly.
//  5. i_rstn low mid-SHIFT -> all outputs 0 immediately (async); after release the block is idle
//     and i_start works.
//  6. A_APPROX=4, macro defined, i_c_in=16'h0120 -> o_data=16'h0128;
//     macro undefined -> 16'h0120; i_start while busy has no effect.

Source files
------------

// File: rtl/psum_drain_pkg.sv
// ---------------------------------------------------------------------------
// psum_drain_pkg
//   Shared types and helpers for the partial-sum drain block.
//   - drain_state_t : drain FSM states
//   - comp_lsb()    : truncation-bias compensation of a partial sum
// ---------------------------------------------------------------------------
package psum_drain_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  // Widest partial sum the compensation helper handles. Callers zero-extend
  // into this width and size-cast the result back down.
  localparam int COMP_MAX_W = 64;

  // Replace bits [approx-1:0] with the midpoint pattern 1000..0. The truncating
  // adders always round towards -inf, so the midpoint cancels the average bias.
  // approx == 0 returns val unchanged. Bits at or above approx are never touched.
  function automatic logic [COMP_MAX_W-1:0] comp_lsb(input logic [COMP_MAX_W-1:0] val,
                                                     input int approx);
    logic [COMP_MAX_W-1:0] res;
    res = val;
    for (int i = 0; i < COMP_MAX_W; i++) begin
      if (i < approx - 1) begin
        res[i] = 1'b0;
      end else if (i == approx - 1) begin
        res[i] = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// ---------------------------------------------------------------------------
// psum_fifo
//   Small synchronous FIFO with first-word fall-through head.
//   Ports:
//     clk, rst_n      clock / asynchronous active-low reset
//     flush           synchronous clear (pointers and count to zero)
//     push, din       write din when push and not full
//     pop             drop head when pop and not empty
//     head            current head entry, zero while empty
//     full, empty     derived from the registered occupancy count
//     count           registered occupancy, $clog2(DEPTH)+1 bits
//   DEPTH must be a power of two (>= 2) so pointers wrap naturally.
// ---------------------------------------------------------------------------
module psum_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Forced to zero while empty so the output is clean after reset/abort.
  assign head    = empty ? '0 : mem[rd_ptr_reg];

  // Storage is not reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/psum_drain.sv
// ---------------------------------------------------------------------------
// psum_drain
//   Reader end of the systolic accumulator chain. On i_start it shifts N_ROWS
//   partial sums out of one array column (one per cycle, throttled by FIFO
//   space), buffers them, and streams them out over valid/ready.
//   Ports:
//     i_clk, i_rstn   clock / asynchronous active-low reset
//     i_start         begin a drain (ignored unless idle)
//     i_abort         synchronous abort: flush, back to idle, no o_done
//     i_c_in          head-of-chain accumulator value, sampled when o_shift=1
//     o_shift         advance the column chain this cycle
//     o_data/o_valid  FIFO head / head valid
//     i_ready         consumer accept
//     o_busy          FSM not idle
//     o_done          one-cycle pulse once all sums have been consumed
//   Build option: define PSUM_DRAIN_BIAS_COMP_EN to replace the A_APPROX
//   truncated LSBs of each pushed sum with the midpoint pattern (OC_W <= 64).
// ---------------------------------------------------------------------------
module psum_drain #(
  parameter int OC_W       = 16,
  parameter int A_APPROX   = 0,
  parameter int N_ROWS     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_start,
  input  logic            i_abort,
  input  logic [OC_W-1:0] i_c_in,
  output logic            o_shift,
  output logic [OC_W-1:0] o_data,
  output logic            o_valid,
  input  logic            i_ready,
  output logic            o_busy,
  output logic            o_done
);

  import psum_drain_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int RW    = $clog2(N_ROWS + 1);

`ifdef PSUM_DRAIN_BIAS_COMP_EN
  localparam bit COMP_EN = 1'b1;
`else
  localparam bit COMP_EN = 1'b0;
`endif
  // Zero compensation bits makes comp_lsb an identity.
  localparam int COMP_BITS = COMP_EN ? A_APPROX : 0;

  drain_state_t    state_reg, state_next;
  logic [RW-1:0]   row_cnt_reg, row_cnt_next;
  logic            push;
  logic            pop;
  logic [OC_W-1:0] push_data;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign push_data = OC_W'(comp_lsb(COMP_MAX_W'(i_c_in), COMP_BITS));

  assign o_valid = ~fifo_empty;
  assign pop     = o_valid & i_ready;
  assign o_busy  = (state_reg != IDLE);
  assign o_done  = (state_reg == DONE);

  psum_fifo #(
    .W     (OC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .flush (i_abort),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .head  (o_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_next   = state_reg;
    row_cnt_next = row_cnt_reg;
    o_shift      = 1'b0;
    push         = 1'b0;
    case (state_reg)
      IDLE: begin
        row_cnt_next = '0;
        if (i_start) state_next = SHIFT;
      end
      SHIFT: begin
        // Full comes from the registered count: a same-cycle pop does not
        // open a slot, keeping the shift decision off the consumer path.
        if (!fifo_full) begin
          o_shift      = 1'b1;
          push         = 1'b1;
          row_cnt_next = row_cnt_reg + 1'b1;
          if (row_cnt_reg == RW'(N_ROWS - 1)) state_next = FLUSH;
        end
      end
      FLUSH: begin
        // Leave as the last entry is popped so o_done follows the final
        // handshake by exactly one cycle.
        if (fifo_empty || (fifo_count == CNT_W'(1) && pop)) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (i_abort) begin
      state_next   = IDLE;
      row_cnt_next = '0;
      o_shift      = 1'b0;
      push         = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg   <= IDLE;
      row_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      row_cnt_reg <= row_cnt_next;
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// ---------------------------------------------------------------------------
// tb_psum_drain
//   Directed bench for psum_drain (OC_W=16, A_APPROX=4, N_ROWS=8, DEPTH=4).
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   on the falling edge.
// ---------------------------------------------------------------------------
module tb_psum_drain;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        abort_s;
  logic [15:0] c_in;
  logic        shift;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        done;

  int vecs = 0;
  int errs = 0;

  logic [15:0] src [8];
  int          sh;
  logic [15:0] out_q [$];

  psum_drain #(
    .OC_W       (16),
    .A_APPROX   (4),
    .N_ROWS     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_start (start),
    .i_abort (abort_s),
    .i_c_in  (c_in),
    .o_shift (shift),
    .o_data  (data),
    .o_valid (valid),
    .i_ready (ready),
    .o_busy  (busy),
    .o_done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value expected on o_data for a pushed chain value.
  function automatic logic [15:0] exp_val(input logic [15:0] v);
`ifdef PSUM_DRAIN_BIAS_COMP_EN
    return {v[15:4], 4'b1000};
`else
    return v;
`endif
  endfunction

  task automatic load_src(input int base);
    for (int i = 0; i < 8; i++) src[i] = 16'(base + i);
  endtask

  // One clock cycle: drive, sample on negedge, advance past the next posedge.
  task automatic cycle(input logic rdy, output logic shf, output logic vld,
                       output logic [15:0] dat, output logic dn, output logic bsy);
    ready = rdy;
    c_in  = (sh < 8) ? src[sh] : 16'h0;
    @(negedge clk);
    shf = shift;
    vld = valid;
    dat = data;
    dn  = done;
    bsy = busy;
    if (shift) sh++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    sh    = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Run until one cycle after o_done (or budget). Records popped data,
  // shift count, the first o_done cycle, o_done count, o_busy after o_done,
  // and how often a stalled o_valid/o_data did not hold.
  task automatic run_until_done(input int rand_rdy, input int budget, input int restart_at,
                                output int n_shift, output int done_at, output int n_done,
                                output logic busy_after, output int n_unstable);
    logic shf, vld, dn, bsy, rdy;
    logic [15:0] dat;
    logic prev_stall;
    logic [15:0] prev_dat;
    n_shift = 0; done_at = -1; n_done = 0; busy_after = 1'bx; n_unstable = 0;
    prev_stall = 1'b0; prev_dat = '0;
    for (int k = 1; k <= budget; k++) begin
      rdy   = (rand_rdy != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (k == restart_at);
      cycle(rdy, shf, vld, dat, dn, bsy);
      start = 1'b0;
      if (prev_stall && (!vld || dat !== prev_dat)) n_unstable++;
      prev_stall = vld & ~rdy;
      prev_dat   = dat;
      if (shf) n_shift++;
      if (vld && rdy) out_q.push_back(dat);
      if (done_at >= 0 && k == done_at + 1) begin
        busy_after = bsy;
        break;
      end
      if (dn) begin
        n_done++;
        if (done_at < 0) done_at = k;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    vecs++;
    if (out_q.size() !== 8) begin
      errs++;
      $display("FAIL %s count: got %0d need 8", tag, out_q.size());
    end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      vecs++;
      if (out_q[i] !== exp_val(src[i])) begin
        errs++;
        $display("FAIL %s data[%0d]: got %h need %h", tag, i, out_q[i], exp_val(src[i]));
      end else begin
        $display("%s data[%0d] = %h", tag, i, out_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; abort_s = 1'b0; ready = 1'b0; c_in = '0; sh = 0;
    #12;
    vecs++;
    if ({shift, valid, busy, done, data} !== 20'h0) begin
      errs++;
      $display("FAIL reset outputs: got shift=%b valid=%b busy=%b done=%b data=%h need all 0",
               shift, valid, busy, done, data);
    end else $display("reset outputs all zero");
    #11;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    int n_shift, done_at, n_done, n_unst;
    logic busy_after;
    load_src(1);
    out_q.delete();
    do_start();
    run_until_done(0, 40, 0, n_shift, done_at, n_done, busy_after, n_unst);
    vecs++;
    if (n_shift !== 8) begin errs++; $display("FAIL stream shifts: got %0d need 8", n_shift); end
    vecs++;
    if (done_at !== 10) begin errs++; $display("FAIL stream done cycle: got %0d need 10", done_at); end
    vecs++;
    if (n_done !== 1) begin errs++; $display("FAIL stream done pulses: got %0d need 1", n_done); end
    vecs++;
    if (busy_after !== 1'b0) begin errs++; $display("FAIL stream busy after done: got %b need 0", busy_after); end
    $display("stream: shifts=%0d done_at=%0d", n_shift, done_at);
    check_outputs("stream");
  endtask

  task automatic test_backpressure();
    int n_shift, done_at, n_done, n_unst, stall_shifts;
    logic shf, vld, dn, bsy, busy_after;
    logic [15:0] dat;
    load_src(11);
    out_q.delete();
    do_start();
    stall_shifts = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, shf, vld, dat, dn, bsy);
      if (shf) stall_shifts++;
    end
    vecs++;
    if (stall_shifts !== 4) begin errs++; $display("FAIL backpressure stalled shifts: got %0d need 4", stall_shifts); end
    vecs++;
    if (shf !== 1'b0 || vld !== 1'b1) begin
      errs++; $display("FAIL backpressure stall state: got shift=%b valid=%b need 0/1", shf, vld);
    end
    run_until_done(0, 40, 0, n_shift, done_at, n_done, busy_after, n_unst);
    vecs++;
    if (stall_shifts + n_shift !== 8) begin
      errs++; $display("FAIL backpressure total shifts: got %0d need 8", stall_shifts + n_shift);
    end
    vecs++;
    if (n_done !== 1) begin errs++; $display("FAIL backpressure done pulses: got %0d need 1", n_done); end
    $display("backpressure: stalled=%0d resumed=%0d", stall_shifts, n_shift);
    check_outputs("backpressure");
  endtask

  task automatic test_random_ready();
    int n_shift, done_at, n_done, n_unst;
    logic busy_after;
    load_src(-3);
    out_q.delete();
    do_start();
    run_until_done(1, 300, 0, n_shift, done_at, n_done, busy_after, n_unst);
    vecs++;
    if (n_unst !== 0) begin errs++; $display("FAIL random stall hold: got %0d violations need 0", n_unst); end
    vecs++;
    if (n_done !== 1) begin errs++; $display("FAIL random done pulses: got %0d need 1", n_done); end
    $display("random: done_at=%0d", done_at);
    check_outputs("random");
  endtask

  task automatic test_abort();
    int n_shift, done_at, n_done, n_unst, pushes, idle_done;
    logic shf, vld, dn, bsy, busy_after;
    logic [15:0] dat;
    load_src(100);
    do_start();
    pushes = 0;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, shf, vld, dat, dn, bsy);
      if (shf) pushes++;
    end
    vecs++;
    if (pushes !== 3) begin errs++; $display("FAIL abort pre-pushes: got %0d need 3", pushes); end
    abort_s = 1'b1;
    cycle(1'b0, shf, vld, dat, dn, bsy);
    abort_s = 1'b0;
    vecs++;
    if (shf !== 1'b0) begin errs++; $display("FAIL abort cycle shift: got %b need 0", shf); end
    cycle(1'b0, shf, vld, dat, dn, bsy);
    vecs++;
    if (bsy !== 1'b0 || vld !== 1'b0 || dn !== 1'b0) begin
      errs++; $display("FAIL abort after: got busy=%b valid=%b done=%b need 0/0/0", bsy, vld, dn);
    end
    idle_done = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, shf, vld, dat, dn, bsy);
      if (dn || vld || shf) idle_done++;
    end
    vecs++;
    if (idle_done !== 0) begin errs++; $display("FAIL abort idle activity: got %0d cycles need 0", idle_done); end
    $display("abort: pushes=%0d then idle", pushes);
    load_src(21);
    out_q.delete();
    do_start();
    run_until_done(0, 40, 0, n_shift, done_at, n_done, busy_after, n_unst);
    vecs++;
    if (done_at !== 10) begin errs++; $display("FAIL abort redrain done cycle: got %0d need 10", done_at); end
    check_outputs("after_abort");
  endtask

  task automatic test_async_reset();
    int n_shift, done_at, n_done, n_unst;
    logic shf, vld, dn, bsy, busy_after;
    logic [15:0] dat;
    load_src(40);
    do_start();
    for (int k = 0; k < 3; k++) cycle(1'b1, shf, vld, dat, dn, bsy);
    #2;
    rstn = 1'b0;
    #1;
    vecs++;
    if ({shift, valid, busy, done, data} !== 20'h0) begin
      errs++;
      $display("FAIL async reset outputs: got shift=%b valid=%b busy=%b done=%b data=%h need all 0",
               shift, valid, busy, done, data);
    end else $display("async reset: outputs zero immediately");
    @(posedge clk);
    #3;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    cycle(1'b1, shf, vld, dat, dn, bsy);
    vecs++;
    if (bsy !== 1'b0 || vld !== 1'b0) begin
      errs++; $display("FAIL post-reset idle: got busy=%b valid=%b need 0/0", bsy, vld);
    end
    load_src(50);
    out_q.delete();
    do_start();
    run_until_done(0, 40, 0, n_shift, done_at, n_done, busy_after, n_unst);
    vecs++;
    if (done_at !== 10) begin errs++; $display("FAIL post-reset done cycle: got %0d need 10", done_at); end
    check_outputs("post_reset");
  endtask

  task automatic test_comp_and_restart();
    int n_shift, done_at, n_done, n_unst;
    logic busy_after;
    logic [15:0] want0;
    for (int i = 0; i < 8; i++) src[i] = 16'h0120;
`ifdef PSUM_DRAIN_BIAS_COMP_EN
    want0 = 16'h0128;
`else
    want0 = 16'h0120;
`endif
    out_q.delete();
    do_start();
    // Second i_start three cycles into SHIFT must change nothing.
    run_until_done(0, 40, 3, n_shift, done_at, n_done, busy_after, n_unst);
    vecs++;
    if (out_q.size() < 1 || out_q[0] !== want0) begin
      errs++; $display("FAIL comp value: got %h need %h", (out_q.size() > 0) ? out_q[0] : 16'hxxxx, want0);
    end else $display("comp: 0120 -> %h", out_q[0]);
    vecs++;
    if (n_shift !== 8 || done_at !== 10 || n_done !== 1 || busy_after !== 1'b0) begin
      errs++;
      $display("FAIL restart while busy: got shifts=%0d done_at=%0d dones=%0d busy_after=%b need 8/10/1/0",
               n_shift, done_at, n_done, busy_after);
    end else $display("restart while busy ignored");
    check_outputs("comp");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random_ready();
    test_abort();
    test_async_reset();
    test_comp_and_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
